// File: rtl/branch_predictor_if.sv
// Lookup / prediction / update / statistics bundle between the core pipeline and branch_predictor.
interface branch_predictor_if #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned IDX_W    = 6
);
    logic                ready;
    logic                lookup_valid;
    logic [PC_WIDTH-1:0] lookup_pc;
    logic                pred_valid;
    logic                pred_taken;
    logic [IDX_W-1:0]    pred_idx;
    logic                upd_valid;
    logic [IDX_W-1:0]    upd_idx;
    logic                upd_taken;
    logic                upd_pred_taken;
    logic                mispredict;
    logic [31:0]         branch_count;
    logic [31:0]         mispred_count;

    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_idx, upd_taken, upd_pred_taken,
        input  ready, pred_valid, pred_taken, pred_idx, mispredict, branch_count, mispred_count
    );

    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_idx, upd_taken, upd_pred_taken,
        output ready, pred_valid, pred_taken, pred_idx, mispredict, branch_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: table of saturating counters, initialised after reset, trained from EX.
// Optional gshare indexing (global history XOR PC bits) is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned ENTRIES    = 64,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter int unsigned HIST_WIDTH = 6
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_WNT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 ready_q, ready_d;
    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0]     pred_idx_q, pred_idx_d;
    logic                 mispredict_q, mispredict_d;
    logic [31:0]          branch_count_q, branch_count_d;
    logic [31:0]          mispred_count_q, mispred_count_d;

    logic [CNT_WIDTH-1:0] table_q [ENTRIES];
    logic                 tbl_we_c;
    logic [IDX_W-1:0]     tbl_waddr_c;
    logic [CNT_WIDTH-1:0] tbl_wdata_c;
    logic [CNT_WIDTH-1:0] upd_cnt_c;
    logic [IDX_W-1:0]     lookup_idx_c;
    logic                 run_upd_c;
    logic                 pc_bits_unused_c;

    assign run_upd_c        = (state_q == S_RUN) && bp.upd_valid;
    assign pc_bits_unused_c = ^{bp.lookup_pc[PC_WIDTH-1:IDX_W+2], bp.lookup_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [HIST_WIDTH-1:0] ghr_q, ghr_d;

    // History shifts in each resolved outcome once the table is live.
    always_comb begin
        ghr_d = ghr_q;
        if (run_upd_c) begin
            ghr_d = HIST_WIDTH'({ghr_q, bp.upd_taken});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign lookup_idx_c = bp.lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
    localparam int unsigned HIST_W_UNUSED = HIST_WIDTH;
    assign lookup_idx_c = bp.lookup_pc[IDX_W+1:2];
`endif

    // Next state, table write port, prediction and statistics.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        pred_valid_d    = bp.lookup_valid;
        pred_taken_d    = pred_taken_q;
        pred_idx_d      = pred_idx_q;
        mispredict_d    = 1'b0;
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        tbl_we_c        = 1'b0;
        tbl_waddr_c     = ptr_q;
        tbl_wdata_c     = CNT_WNT;
        upd_cnt_c       = table_q[bp.upd_idx];

        case (state_q)
            S_INIT: begin
                tbl_we_c = 1'b1;
                ptr_d    = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bp.upd_valid) begin
                    tbl_we_c    = 1'b1;
                    tbl_waddr_c = bp.upd_idx;
                    if (bp.upd_taken) begin
                        tbl_wdata_c = (upd_cnt_c == CNT_MAX) ? upd_cnt_c : upd_cnt_c + CNT_WIDTH'(1);
                    end else begin
                        tbl_wdata_c = (upd_cnt_c == '0) ? upd_cnt_c : upd_cnt_c - CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        ready_d = (state_d == S_RUN);

        // Reads use the pre-write table contents, so a same-cycle update is seen next lookup.
        if (bp.lookup_valid) begin
            pred_idx_d   = lookup_idx_c;
            pred_taken_d = (state_q == S_RUN) && table_q[lookup_idx_c][CNT_WIDTH-1];
        end

        if (run_upd_c) begin
            mispredict_d = bp.upd_taken ^ bp.upd_pred_taken;
            if (branch_count_q != 32'hFFFF_FFFF) begin
                branch_count_d = branch_count_q + 32'd1;
            end
            if (mispredict_d && (mispred_count_q != 32'hFFFF_FFFF)) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_INIT;
            ptr_q           <= '0;
            ready_q         <= 1'b0;
            pred_valid_q    <= 1'b0;
            pred_taken_q    <= 1'b0;
            pred_idx_q      <= '0;
            mispredict_q    <= 1'b0;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            ready_q         <= ready_d;
            pred_valid_q    <= pred_valid_d;
            pred_taken_q    <= pred_taken_d;
            pred_idx_q      <= pred_idx_d;
            mispredict_q    <= mispredict_d;
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    // Counter storage is not reset; the INIT sweep defines its contents.
    always_ff @(posedge clk) begin
        if (tbl_we_c) begin
            table_q[tbl_waddr_c] <= tbl_wdata_c;
        end
    end

    assign bp.ready         = ready_q;
    assign bp.pred_valid    = pred_valid_q;
    assign bp.pred_taken    = pred_taken_q;
    assign bp.pred_idx      = pred_idx_q;
    assign bp.mispredict    = mispredict_q;
    assign bp.branch_count  = branch_count_q;
    assign bp.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=64, CNT_WIDTH=2, HIST_WIDTH=6).
module tb_branch_predictor;
    localparam int unsigned IDX_W = 6;

    typedef struct {
        logic        lv;
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  ui;
        logic        ut;
        logic        upt;
        logic        e_pv;
        logic        e_pt;
        logic [5:0]  e_idx;
        logic        e_mis;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cycles;
    vec_t vecs [17];

    branch_predictor_if #(.PC_WIDTH(32), .IDX_W(IDX_W)) bp_if ();

    branch_predictor #(
        .PC_WIDTH  (32),
        .ENTRIES   (64),
        .CNT_WIDTH (2),
        .HIST_WIDTH(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bp_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic lv, input logic [31:0] pc, input logic uv,
                         input logic [5:0] ui, input logic ut, input logic upt);
        bp_if.lookup_valid   = lv;
        bp_if.lookup_pc      = pc;
        bp_if.upd_valid      = uv;
        bp_if.upd_idx        = ui;
        bp_if.upd_taken      = ut;
        bp_if.upd_pred_taken = upt;
    endtask

    // Inputs change at posedge+1, outputs are sampled at posedge+1 after the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_wait(input bit traffic, output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (traffic) drive(1'b1, 32'h10, 1'b1, 6'd4, 1'b1, 1'b0);
            else         drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
            tick();
            n++;
            if (traffic) begin
                chk($sformatf("init%0d pred_valid", n), 32'(bp_if.pred_valid), 32'd1);
                chk($sformatf("init%0d pred_taken", n), 32'(bp_if.pred_taken), 32'd0);
                chk($sformatf("init%0d mispredict", n), 32'(bp_if.mispredict), 32'd0);
                chk($sformatf("init%0d branch_count", n), bp_if.branch_count, 32'd0);
                chk($sformatf("init%0d mispred_count", n), bp_if.mispred_count, 32'd0);
            end
            if (bp_if.ready) break;
        end
        drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    initial begin
        //          lv  pc            uv  ui  ut upt  pv pt idx mis bc  mc
        vecs[0]  = '{1, 32'h10,       0,  0,  0, 0,   1, 0, 4,  0,  0,  0};
        vecs[1]  = '{0, 32'h0,        1,  4,  1, 1,   0, 0, 4,  0,  1,  0};
        vecs[2]  = '{1, 32'h10,       0,  0,  0, 0,   1, 1, 4,  0,  1,  0};
        vecs[3]  = '{0, 32'h0,        1,  4,  1, 1,   0, 1, 4,  0,  2,  0};
        vecs[4]  = '{0, 32'h0,        1,  4,  1, 1,   0, 1, 4,  0,  3,  0};
        vecs[5]  = '{1, 32'h10,       0,  0,  0, 0,   1, 1, 4,  0,  3,  0};
        vecs[6]  = '{0, 32'h0,        1,  4,  0, 1,   0, 1, 4,  1,  4,  1};
        vecs[7]  = '{1, 32'h10,       0,  0,  0, 0,   1, 1, 4,  0,  4,  1};
        vecs[8]  = '{0, 32'h0,        1,  4,  0, 1,   0, 1, 4,  1,  5,  2};
        vecs[9]  = '{1, 32'h10,       1,  4,  1, 0,   1, 0, 4,  1,  6,  3};
        vecs[10] = '{1, 32'h10,       0,  0,  0, 0,   1, 1, 4,  0,  6,  3};
        vecs[11] = '{1, 32'h104,      1, 63,  0, 0,   1, 0, 1,  0,  7,  3};
        vecs[12] = '{1, 32'hFC,       1, 63,  0, 0,   1, 0, 63, 0,  8,  3};
        vecs[13] = '{0, 32'h0,        1, 63,  1, 0,   0, 0, 63, 1,  9,  4};
        vecs[14] = '{0, 32'h0,        1, 63,  1, 1,   0, 0, 63, 0,  10, 4};
        vecs[15] = '{1, 32'hFC,       0,  0,  0, 0,   1, 1, 63, 0,  10, 4};
        vecs[16] = '{1, 32'hFFFF_FF10, 0, 0,  0, 0,   1, 1, 4,  0,  10, 4};

        // Power-on reset and first INIT sweep
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(bp_if.ready), 32'd0);
        chk("reset pred_valid", 32'(bp_if.pred_valid), 32'd0);
        chk("reset pred_idx", 32'(bp_if.pred_idx), 32'd0);
        chk("reset mispredict", 32'(bp_if.mispredict), 32'd0);
        chk("reset branch_count", bp_if.branch_count, 32'd0);
        reset = 1'b1;
        init_wait(1'b0, cycles);
        chk("init length", 32'(cycles), 32'd64);
        chk("ready after init", 32'(bp_if.ready), 32'd1);

`ifdef BP_GSHARE_EN
        drive(1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b1);
        tick();
        chk("gshare branch_count", bp_if.branch_count, 32'd1);
        drive(1'b1, 32'h10, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        chk("gshare pred_idx", 32'(bp_if.pred_idx), 32'd5);
        chk("gshare pred_taken", 32'(bp_if.pred_taken), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].lv, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut, vecs[i].upt);
            tick();
            chk($sformatf("v%0d pred_valid", i), 32'(bp_if.pred_valid), 32'(vecs[i].e_pv));
            chk($sformatf("v%0d pred_taken", i), 32'(bp_if.pred_taken), 32'(vecs[i].e_pt));
            chk($sformatf("v%0d pred_idx", i), 32'(bp_if.pred_idx), 32'(vecs[i].e_idx));
            chk($sformatf("v%0d mispredict", i), 32'(bp_if.mispredict), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d branch_count", i), bp_if.branch_count, vecs[i].e_bc);
            chk($sformatf("v%0d mispred_count", i), bp_if.mispred_count, vecs[i].e_mc);
        end
        drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
`endif

        // Asynchronous reset out of RUN clears outputs before any clock edge
        reset = 1'b0;
        #1;
        chk("async ready", 32'(bp_if.ready), 32'd0);
        chk("async branch_count", bp_if.branch_count, 32'd0);
        chk("async mispred_count", bp_if.mispred_count, 32'd0);
        chk("async pred_taken", 32'(bp_if.pred_taken), 32'd0);
        repeat (2) tick();
        reset = 1'b1;

        // Abort INIT at cycle 20 and restart with traffic during the new sweep
        repeat (20) tick();
        chk("mid-init ready", 32'(bp_if.ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid-init reset ready", 32'(bp_if.ready), 32'd0);
        tick();
        reset = 1'b1;
        init_wait(1'b1, cycles);
        chk("restart init length", 32'(cycles), 32'd64);
        chk("restart ready", 32'(bp_if.ready), 32'd1);

        drive(1'b1, 32'h10, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        chk("post-restart pred_taken", 32'(bp_if.pred_taken), 32'd0);
        chk("post-restart pred_idx", 32'(bp_if.pred_idx), 32'd4);
        chk("post-restart branch_count", bp_if.branch_count, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
